// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/full-subtractor cell, LSB first, WIDTH cycles per operation.
// Optional signed-overflow flag is built only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, work;
  logic [CW-1:0]    cnt;
  logic             mode_q, carry;
  logic             last, accept;
  logic             abit, bbit, sbit, carry_nxt;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state != RUN) && start;
  assign abit   = op_a[0];
  assign bbit   = op_b[0];
  assign sbit   = abit ^ bbit ^ carry;

  // Carry for add, borrow for subtract
  always_comb begin
    carry_nxt = 1'b0;
    if (mode_q)
      carry_nxt = (abit & bbit) | (abit & carry) | (bbit & carry);
    else
      carry_nxt = (~abit & bbit) | (~(abit ^ bbit) & carry);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so outputs stay registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      work   <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      op_a   <= a;
      op_b   <= b;
      mode_q <= mode;
      carry  <= cin;
      cnt    <= '0;
      work   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= carry_nxt;
      work  <= {sbit, work[WIDTH-1:1]};
      if (last) begin
        result <= {sbit, work[WIDTH-1:1]};
        cout   <= carry_nxt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic a_msb, b_msb;

  // Operand MSBs are captured at start because the shift registers discard them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN && last) begin
      if (mode_q)
        overflow <= (a_msb == b_msb) && (sbit != a_msb);
      else
        overflow <= (a_msb != b_msb) && (sbit != a_msb);
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed bench for serial_addsub (WIDTH=8) against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, cout, result} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] ia, ib, input logic im, ic);
    logic [W:0] full;
    logic       ovf;
    if (im) full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    else    full = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ic};
    ovf = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    if (im) ovf = (ia[W-1] == ib[W-1]) && (full[W-1] != ia[W-1]);
    else    ovf = (ia[W-1] != ib[W-1]) && (full[W-1] != ia[W-1]);
`endif
    return {ovf, full};
  endfunction

  task automatic apply_stimulus(input logic [W-1:0] ia, ib, input logic im, ic, input bit disturb);
    logic [W+1:0] exp;
    int cyc;
    exp = model(ia, ib, im, ic);
    @(negedge clk);
    a = ia; b = ib; mode = im; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_after_start", 64'(busy), 64'(1));
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 2) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); mode = ~im; cin = ~ic;
      end
      if (disturb && cyc == 3) start = 1'b0;
      if (!done) check_output("busy_in_run", 64'(busy), 64'(1));
    end
    check_output("latency", 64'(cyc), 64'(W));
    check_output("busy_at_done", 64'(busy), 64'(0));
    check_output("result", 64'(result), 64'(exp[W-1:0]));
    check_output("cout", 64'(cout), 64'(exp[W]));
    check_output("overflow", 64'(overflow), 64'(exp[W+1]));
  endtask

  initial begin
    logic [W+1:0] exp;
    int cyc;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_done", 64'(done), 64'(0));
    check_output("rst_result", 64'(result), 64'(0));
    check_output("rst_cout", 64'(cout), 64'(0));
    check_output("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    apply_stimulus(8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
    apply_stimulus(8'h7F, 8'h01, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h05, 8'h07, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b1);

    // Start held through DONE launches the next operation immediately
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; mode = 1'b1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_output("b2b_first_latency", 64'(cyc), 64'(W));
    check_output("b2b_first_result", 64'(result), 64'(8'h4B));
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check_output("b2b_busy_restart", 64'(busy), 64'(1));
        check_output("b2b_result_held", 64'(result), 64'(8'h4B));
      end
    end while (!done && cyc < 20);
    check_output("b2b_spacing", 64'(cyc), 64'(W + 1));
    check_output("b2b_second_result", 64'(result), 64'(8'h30));

    // Asynchronous abort in the middle of an operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; mode = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", 64'(busy), 64'(0));
    check_output("abort_done", 64'(done), 64'(0));
    check_output("abort_result", 64'(result), 64'(0));
    check_output("abort_cout", 64'(cout), 64'(0));
    check_output("abort_overflow", 64'(overflow), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) check_output("abort_no_done", 64'(done), 64'(0));
    end
    apply_stimulus(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      apply_stimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    exp = model(8'h7F, 8'h01, 1'b1, 1'b0);
    $display("[TB] reference overflow for 0x7F+0x01 = %0d", exp[W+1]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor. It processes one bit pair per clock, LSB first, through a single full-adder/full-subtractor cell, using the same per-bit equations as our single-bit combinational adder/subtractor. A WIDTH-bit operation completes in WIDTH cycles under a start/done handshake. The block is the area-optimised arithmetic engine for slow control paths where a WIDTH-bit ripple adder is not wanted.

## Interface
- WIDTH, 8, operand/result width in bits; legal 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- mode  input  1  1 = add, 0 = subtract (a − b).
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  sum or difference. Held until the next completion.
- cout  output  1  carry-out (add) or borrow-out (subtract) of the MSB.
- overflow  output  1  signed overflow. See Configuration.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Start acceptance:
  - IDLE or DONE with start=1: latch a, b, mode and cin into operand shift registers; clear bit counter cnt; go to RUN.
  - DONE with start=0: go to IDLE.
  - IDLE with start=0: stay in IDLE.
- RUN, each edge, for bit i = cnt:
  - Add: s = a_i^b_i^c; c' = a_i&b_i | a_i&c | b_i&c.
  - Sub: d = a_i^b_i^c; c' = ~a_i&b_i | ~(a_i^b_i)&c.
  - Shift the result bit into the MSB of the working shift register; store c'; cnt++.
- Final RUN edge (cnt = WIDTH−1): load the completed value into result, the final c' into cout and the overflow flag into overflow; go to DONE.
- start, mode, a, b and cin are ignored while in RUN. The latched copies are used.
- cnt width is clog2(WIDTH). No wrap beyond WIDTH−1.
- Reset values: busy=0, done=0, result=0, cout=0, overflow=0, state=IDLE, cnt=0, all working registers 0.
- Asserting rst_n low mid-operation aborts immediately and asynchronously. No done pulse is produced for the aborted operation.

## Timing
- Let E0 be the edge that samples start in IDLE or DONE.
- Bits are processed on edges E1..EWIDTH.
- done=1 and busy=0 from EWIDTH to EWIDTH+1 (exactly one cycle). result, cout and overflow are valid from EWIDTH onward.
- busy=1 from E0 until EWIDTH.
- Latency is WIDTH cycles from the start edge to done.
- Throughput: start held high during DONE begins the next operation at EWIDTH+1. This gives back-to-back operations every WIDTH+1 cycles.
- result, cout and overflow change only at a completion edge or at reset. They stay stable during a subsequent RUN.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - Add: overflow = (a_msb == b_msb) & (r_msb != a_msb).
  - Sub: overflow = (a_msb != b_msb) & (r_msb != a_msb).
  - The flag is registered at completion alongside result.
- SERIAL_ADDSUB_OVF_EN undefined: overflow is tied to 0, and no MSB-capture logic is built.

## Test plan
All scenarios use WIDTH=8.
- Add 0x3C + 0x0F, cin=0 -> result=0x4B, cout=0, overflow=0. done is pulsed exactly 8 cycles after the start edge and busy is high for 8 cycles.
- Add 0xFF + 0x01, cin=1 -> result=0x01, cout=1, overflow=0. Add 0x7F + 0x01, cin=0 -> result=0x80, cout=0, overflow=1 with SERIAL_ADDSUB_OVF_EN defined, 0 without.
- Sub 0x05 − 0x07, borrow-in 0 -> result=0xFE, cout=1, overflow=0. Sub 0x80 − 0x01 -> result=0x7F, cout=0, overflow=1 (macro defined). Sub 0x00 − 0x00 with borrow-in 1 -> 0xFF, cout=1.
- start pulsed, and a/b/mode changed, during RUN -> no effect; the original operation's result is reported, and the next done comes 8 cycles after the original start.
- start held high through DONE with new operands 0x10 + 0x20 -> the second done arrives 9 cycles after the first, with result=0x30; the first result stays on result until then.
- rst_n driven low at RUN cycle 4 -> busy, done, result, cout and overflow are 0 immediately. After release, a fresh add of 0x01 + 0x01 returns 0x02 in 8 cycles.
